// File: rtl/booth_acc_pkg.sv
// booth_acc_pkg: shared types and sizing for booth_pp_accumulator.
package booth_acc_pkg;
  localparam int PP_W_DEF = 16;
  localparam int NUM_PP_DEF = 4;
  localparam int CNT_W = $clog2(NUM_PP_DEF);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
endpackage

// File: rtl/adder_cla16.sv
// adder_cla16: carry-lookahead adder, 4-bit groups with lookahead group carries.
module adder_cla16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o
);
  localparam int N = W / 4;
  logic [W-1:0] p, g, c;
  logic cg, cb, gk;
  always_comb begin
    p = a_i ^ b_i;
    g = a_i & b_i;
    c = '0;
    cg = 1'b0;
    cb = 1'b0;
    gk = 1'b0;
    for (int k = 0; k < N; k++) begin
      cb = cg;
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = cb;
        cb = g[4*k+j] | (p[4*k+j] & cb);
      end
      gk = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1]) | (&p[4*k+3 -: 3] & g[4*k]);
      cg = gk | (&p[4*k +: 4] & cg);
    end
  end
  assign s_o = p ^ c;
endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sums four Booth partial products through one shared adder over three cycles.
// Define BOOTH_ACC_MAC_EN to add the mac_clr/mac_sum running accumulator.
module booth_pp_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PP_W = PP_W_DEF,
  parameter int NUM_PP = NUM_PP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [PP_W-1:0] pp0,
  input  logic signed [PP_W-1:0] pp1,
  input  logic signed [PP_W-1:0] pp2,
  input  logic signed [PP_W-1:0] pp3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [PP_W-1:0] product,
  output logic                   busy
`ifdef BOOTH_ACC_MAC_EN
  ,
  input  logic                   mac_clr,
  output logic signed [PP_W-1:0] mac_sum
`endif
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PP_W-1:0] acc_q, acc_d, pp1_q, pp2_q, pp3_q, addend, sum;
  logic accept;
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign addend = (cnt_q == CNT_W'(1)) ? pp1_q : (cnt_q == CNT_W'(2)) ? pp2_q : pp3_q;
  adder_cla16 #(.W(PP_W)) u_add (.a_i(acc_q), .b_i(addend), .s_o(sum));
  // A DONE-cycle handshake may reload immediately, so accept overrides the step.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (state_q == ACC) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(NUM_PP - 1)) ? DONE : ACC;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (accept) begin
      state_d = ACC;
      acc_d = pp0;
      cnt_d = CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      pp1_q <= '0;
      pp2_q <= '0;
      pp3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      if (accept) begin
        pp1_q <= pp1;
        pp2_q <= pp2;
        pp3_q <= pp3;
      end
    end
  end
  assign out_valid = state_q == DONE;
  assign product = acc_q;
  assign busy = state_q != IDLE;
`ifdef BOOTH_ACC_MAC_EN
  logic [PP_W-1:0] mac_q, mac_d;
  logic hs;
  assign hs = out_valid && out_ready;
  assign mac_d = mac_clr ? (hs ? acc_q : '0) : (hs ? mac_q + acc_q : mac_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mac_q <= '0;
    else mac_q <= mac_d;
  end
  assign mac_sum = mac_q;
`endif
endmodule
